uc_bus_master: RTL and testbench
================================

// Module: uc_bus_master
// PURPOSE
//  Microcontroller-side initiator for the cartridge CPLD's uc_* SRAM port: turns host byte
//  commands into set_addr_lo/hi + strobe_addr address loads and uc_write/uc_read 4-phase
//  handshakes against uc_ack. Keeps a shadow of the CPLD address counter, skipping or
//  shortening address loads. Sits in the loader controller between the SD/file engine and the CPLD pins.
// PARAMETERS
//  SETUP_CYC   2     clk cycles uc_data/set_addr_* stable before strobe_addr rises (>=1)
//  STROBE_CYC  2     clk cycles strobe_addr held high (>=1)
//  HOLD_CYC    1     clk cycles uc_data/set_addr_* held after strobe_addr falls (>=1)
//  TIMEOUT     1023  max clk cycles waiting on any uc_ack edge before abort (10-bit counter)
// PORTS
//  clk           in   1   system clock; single clock domain
//  rst_n         in   1   asynchronous active-low reset
//  cmd_valid     in   1   host command request
//  cmd_ready     out  1   high only in IDLE; command accepted when cmd_valid & cmd_ready
//  cmd_write     in   1   1 = write byte, 0 = read byte
//  cmd_addr      in   15  SRAM byte address
//  cmd_wdata     in   8   write data
//  rsp_valid     out  1   one-cycle pulse: command finished
//  rsp_rdata     out  8   read data, valid with rsp_valid (holds until next rsp_valid)
//  rsp_timeout   out  1   valid with rsp_valid: uc_ack handshake timed out
//  uc_data_out   out  8   to bidirectional uc_data pad
//  uc_data_oe    out  1   pad output enable
//  uc_data_in    in   8   from uc_data pad
//  uc_write      out  1   write request to CPLD
//  uc_read       out  1   read request to CPLD
//  uc_ack        in   1   CPLD acknowledge (asynchronous; 2-flop synchronised internally)
//  set_addr_lo   out  1   strobe selects address bits [7:0]
//  set_addr_hi   out  1   strobe selects address bits [14:8] (uc_data[6:0])
//  strobe_addr   out  1   CPLD latches/increments address on rising edge
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; uc_data_out=0; shadow_valid=0; state IDLE.
//  Accept: latch cmd_* in IDLE. Address path chosen vs shadow:
//   shadow_valid & addr==shadow      -> skip straight to XFER
//   shadow_valid & addr==shadow+1    -> INC: strobe_addr with both set_addr_* low (no data drive)
//     (shadow+1 wraps 15 bits: 7FFF+1=0000)
//   otherwise                         -> LO load (uc_data=addr[7:0], set_addr_lo) then HI load
//                                        (uc_data={1'b0,addr[14:8]}, set_addr_hi)
//  Each strobe phase: SETUP_CYC with strobe low, STROBE_CYC high, HOLD_CYC low; set_addr_*,
//   uc_data_out, uc_data_oe constant across all three. One idle cycle (all low, oe=0) between LO and HI.
//  Shadow updated to cmd_addr when the final strobe falls; shadow_valid=1.
//  XFER write: drive uc_data_out=wdata, oe=1 one cycle, then uc_write=1; wait ack_s=1;
//   uc_write=0 and oe=0 next cycle; wait ack_s=0; rsp_valid.
//  XFER read: oe must already be 0 >=1 cycle; uc_read=1; wait ack_s=1; capture uc_data_in
//   into rsp_rdata that cycle; uc_read=0; wait ack_s=0; rsp_valid.
//  Never uc_read=1 while uc_data_oe=1; never uc_read & uc_write together; never start
//   XFER while ack_s=1 (wait, counted toward timeout).
//  CPLD does not auto-increment on transfer: shadow unchanged by XFER.
//  Timeout: counter clears on each state entry; reaching TIMEOUT in any ack wait drops
//   uc_read/uc_write/oe, sets shadow_valid=0, pulses rsp_valid with rsp_timeout=1,
//   rsp_rdata unchanged, returns to IDLE (does not wait ack low).
//  rsp_valid occurs with cmd_ready=1 in the same cycle; a new command may be accepted next cycle.
//  cmd_* changes while busy ignored. Reset mid-operation: all strobes/requests drop immediately
//   (async), shadow invalidated.
// TESTING
//  Reset, write 0x1234<=0xA5 -> LO strobe data 0x34, HI strobe data 0x12, uc_write until ack, rsp ok.
//  Then read 0x1234 (model returns 0x5A) -> no strobe_addr, rsp_rdata=0x5A, rsp_timeout=0.
//  Then read 0x1235 -> exactly one strobe_addr, set_addr_lo=set_addr_hi=0, uc_data_oe=0.
//  Shadow 0x7FFF, access 0x0000 -> single increment strobe; shadow 0x0010, access 0x0012 -> full load.
//  Model never acks a write -> after TIMEOUT cycles rsp_valid & rsp_timeout=1; next access does full load.
//  Read with ack delayed 200 cycles; assert every cycle: !(uc_read&uc_data_oe), !(uc_read&uc_write);
//   rst_n pulled low mid-HI-strobe -> all outputs 0 same cycle, cmd_ready=1.

Source files
------------

// File: rtl/uc_bus_master.sv
// uc_bus_master: host byte commands -> CPLD uc_* address loads and 4-phase
// uc_write/uc_read handshakes. A shadow of the CPLD address counter lets the
// block skip an address load (same address) or use a single increment strobe
// (next address) instead of a full LO/HI load.
module uc_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [14:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [7:0]  uc_data_out,
    output logic        uc_data_oe,
    input  logic [7:0]  uc_data_in,
    output logic        uc_write,
    output logic        uc_read,
    input  logic        uc_ack,
    output logic        set_addr_lo,
    output logic        set_addr_hi,
    output logic        strobe_addr
);

    typedef enum logic [3:0] {
        S_IDLE, S_LO, S_GAP, S_HI, S_INC, S_XWAIT,
        S_WDRV, S_WREQ, S_WREL, S_RREQ, S_RREL
    } state_t;

    typedef struct packed {
        logic        write;
        logic [14:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    // One 10-bit counter serves both as strobe-phase position and as the
    // ack-wait timeout; it clears whenever the state changes.
    localparam logic [9:0] STB_ON   = 10'(SETUP_CYC);
    localparam logic [9:0] STB_OFF  = 10'(SETUP_CYC + STROBE_CYC);
    localparam logic [9:0] STB_LAST = 10'(SETUP_CYC + STROBE_CYC - 1);
    localparam logic [9:0] PH_LAST  = 10'(SETUP_CYC + STROBE_CYC + HOLD_CYC - 1);
    localparam logic [9:0] TMO_LIM  = 10'(TIMEOUT);

    state_t      state, state_nx;
    logic [9:0]  cnt;
    cmd_t        cmd_q;
    logic [14:0] shadow;
    logic        shadow_valid;
    logic        ack_meta, ack_s;
    logic [14:0] shadow_inc;

    logic accept, shadow_set, capture, abort, done;
    logic in_strobe, ph_end, stb_fall, tmo_hit;

    assign shadow_inc = shadow + 15'd1;
    assign in_strobe  = (cnt >= STB_ON) && (cnt < STB_OFF);
    assign ph_end     = (cnt == PH_LAST);
    assign stb_fall   = (cnt == STB_LAST);
    assign tmo_hit    = (cnt == TMO_LIM);

    // uc_ack is asynchronous to clk: two-flop synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta <= 1'b0;
            ack_s    <= 1'b0;
        end else begin
            ack_meta <= uc_ack;
            ack_s    <= ack_meta;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Phase / timeout counter, saturating so a long wait cannot wrap past the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (state_nx != state) cnt <= '0;
        else if (cnt != 10'h3FF)    cnt <= cnt + 10'd1;
    end

    // Command latch; inputs are ignored outside the accepting cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cmd_q <= '0;
        else if (accept) cmd_q <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end

    // Shadow of the CPLD address counter; any timeout leaves the CPLD state unknown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow       <= '0;
            shadow_valid <= 1'b0;
        end else if (abort) begin
            shadow_valid <= 1'b0;
        end else if (shadow_set) begin
            shadow       <= cmd_q.addr;
            shadow_valid <= 1'b1;
        end
    end

    // Response outputs; read data is taken on the cycle the synchronised ack rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid   <= done | abort;
            rsp_timeout <= abort;
            if (capture) rsp_rdata <= uc_data_in;
        end
    end

    // Next-state and pin decode
    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        uc_write    = 1'b0;
        uc_read     = 1'b0;
        uc_data_oe  = 1'b0;
        uc_data_out = 8'h00;
        set_addr_lo = 1'b0;
        set_addr_hi = 1'b0;
        strobe_addr = 1'b0;
        accept      = 1'b0;
        shadow_set  = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (shadow_valid && cmd_addr == shadow)          state_nx = S_XWAIT;
                    else if (shadow_valid && cmd_addr == shadow_inc) state_nx = S_INC;
                    else                                             state_nx = S_LO;
                end
            end
            S_LO: begin
                uc_data_oe  = 1'b1;
                uc_data_out = cmd_q.addr[7:0];
                set_addr_lo = 1'b1;
                strobe_addr = in_strobe;
                if (ph_end) state_nx = S_GAP;
            end
            S_GAP: state_nx = S_HI;
            S_HI: begin
                uc_data_oe  = 1'b1;
                uc_data_out = {1'b0, cmd_q.addr[14:8]};
                set_addr_hi = 1'b1;
                strobe_addr = in_strobe;
                shadow_set  = stb_fall;
                if (ph_end) state_nx = S_XWAIT;
            end
            S_INC: begin
                strobe_addr = in_strobe;
                shadow_set  = stb_fall;
                if (ph_end) state_nx = S_XWAIT;
            end
            S_XWAIT: begin
                // bus is released here, so a read never overlaps a driven pad
                if (!ack_s)       state_nx = cmd_q.write ? S_WDRV : S_RREQ;
                else if (tmo_hit) abort = 1'b1;
            end
            S_WDRV: begin
                uc_data_oe  = 1'b1;
                uc_data_out = cmd_q.wdata;
                state_nx    = S_WREQ;
            end
            S_WREQ: begin
                uc_data_oe  = 1'b1;
                uc_data_out = cmd_q.wdata;
                uc_write    = 1'b1;
                if (ack_s)        state_nx = S_WREL;
                else if (tmo_hit) abort = 1'b1;
            end
            S_WREL: begin
                if (!ack_s)       done = 1'b1;
                else if (tmo_hit) abort = 1'b1;
            end
            S_RREQ: begin
                uc_read = 1'b1;
                if (ack_s) begin
                    capture  = 1'b1;
                    state_nx = S_RREL;
                end else if (tmo_hit) begin
                    abort = 1'b1;
                end
            end
            S_RREL: begin
                if (!ack_s)       done = 1'b1;
                else if (tmo_hit) abort = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
        if (done || abort) state_nx = S_IDLE;
    end

endmodule

// File: tb/tb_uc_bus_master.sv
// Bench for uc_bus_master: CPLD responder + address-counter model, host-level
// shadow/memory reference model, directed scenarios and a random command mix.
module tb_uc_bus_master;
    localparam int TMO = 1023;

    logic        clk = 0, rst_n = 0;
    logic        cmd_valid = 0, cmd_write = 0;
    logic [14:0] cmd_addr = 0;
    logic [7:0]  cmd_wdata = 0;
    logic        cmd_ready, rsp_valid, rsp_timeout;
    logic [7:0]  rsp_rdata, uc_data_out, uc_data_in = 0;
    logic        uc_data_oe, uc_write, uc_read, uc_ack = 0;
    logic        set_addr_lo, set_addr_hi, strobe_addr;

    uc_bus_master #(.SETUP_CYC(2), .STROBE_CYC(2), .HOLD_CYC(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .uc_data_out(uc_data_out), .uc_data_oe(uc_data_oe), .uc_data_in(uc_data_in),
        .uc_write(uc_write), .uc_read(uc_read), .uc_ack(uc_ack),
        .set_addr_lo(set_addr_lo), .set_addr_hi(set_addr_hi), .strobe_addr(strobe_addr));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // CPLD model state
    logic [7:0]  cpld_mem [0:32767];
    logic [14:0] cpld_addr = 0, xfer_addr = 0;
    int          ack_delay = 0, req_cnt = 0;
    logic        no_ack_write = 0;

    // monitor counters
    int n_strobe, n_lo, n_hi, n_inc, inc_bad;
    logic [7:0] lo_data, hi_data, stb_data;
    logic stb_lo, stb_hi, stb_oe, prev_stb = 0;

    // host-level reference model
    logic [7:0]  ref_mem [0:32767];
    logic        m_valid = 0;
    logic [14:0] m_shadow = 0;
    logic [7:0]  last_rdata = 0;

    // CPLD ack responder
    initial forever begin
        @(negedge clk);
        if (!uc_ack) begin
            if ((uc_write && !no_ack_write) || uc_read) begin
                req_cnt++;
                if (req_cnt >= ack_delay) begin
                    if (uc_write) begin
                        checks++;
                        if (uc_data_oe !== 1'b1) begin
                            errors++; $display("FAIL wr_oe: got %0b want 1", uc_data_oe);
                        end
                        cpld_mem[cpld_addr] = uc_data_out;
                    end else begin
                        uc_data_in = cpld_mem[cpld_addr];
                    end
                    xfer_addr = cpld_addr;
                    uc_ack = 1;
                    req_cnt = 0;
                end
            end else req_cnt = 0;
        end else if (!uc_write && !uc_read) begin
            uc_ack = 0;
        end
    end

    // CPLD address counter and bus-protocol monitor
    initial forever begin
        @(negedge clk);
        if (!rst_n) prev_stb = 0;
        else begin
            checks++;
            if (uc_read && uc_data_oe) begin errors++; $display("FAIL rd_oe_overlap: got 1 want 0"); end
            checks++;
            if (uc_read && uc_write) begin errors++; $display("FAIL rd_wr_overlap: got 1 want 0"); end
            if (!prev_stb && strobe_addr) begin
                n_strobe++;
                stb_data = uc_data_out; stb_lo = set_addr_lo; stb_hi = set_addr_hi; stb_oe = uc_data_oe;
                if (set_addr_lo) begin cpld_addr[7:0] = uc_data_out; n_lo++; lo_data = uc_data_out; end
                else if (set_addr_hi) begin cpld_addr[14:8] = uc_data_out[6:0]; n_hi++; hi_data = uc_data_out; end
                else begin cpld_addr = cpld_addr + 15'd1; n_inc++; if (uc_data_oe) inc_bad++; end
            end
            if (prev_stb && !strobe_addr) begin
                checks++;
                if ({uc_data_out, set_addr_lo, set_addr_hi, uc_data_oe} !== {stb_data, stb_lo, stb_hi, stb_oe}) begin
                    errors++;
                    $display("FAIL strobe_hold: got %h/%b%b%b want %h/%b%b%b", uc_data_out, set_addr_lo,
                             set_addr_hi, uc_data_oe, stb_data, stb_lo, stb_hi, stb_oe);
                end
            end
            prev_stb = strobe_addr;
        end
    end

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({uc_write, uc_read, uc_data_oe, uc_data_out, set_addr_lo, set_addr_hi, strobe_addr,
             rsp_valid, rsp_rdata, rsp_timeout, cmd_ready} !== {22'd0, 1'b1}) begin
            errors++;
            $display("FAIL %s: got wr%b rd%b oe%b do%h lo%b hi%b stb%b rv%b rd%h to%b rdy%b want all 0 rdy1",
                     tag, uc_write, uc_read, uc_data_oe, uc_data_out, set_addr_lo, set_addr_hi,
                     strobe_addr, rsp_valid, rsp_rdata, rsp_timeout, cmd_ready);
        end
    endtask

    // Issue one command and check the response against the reference model.
    task automatic run_cmd(input string tag, input logic wr, input logic [14:0] addr,
                           input logic [7:0] wd, input logic exp_tmo);
        int exp_stb, cyc;
        logic [14:0] nxt;
        logic [7:0] exp_rd;
        nxt = m_shadow + 15'd1;
        if (m_valid && addr == m_shadow) exp_stb = 0;
        else if (m_valid && addr == nxt) exp_stb = 1;
        else exp_stb = 2;
        cyc = 0;
        while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
        n_strobe = 0; n_lo = 0; n_hi = 0; n_inc = 0; inc_bad = 0;
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0; cmd_write = 1'($urandom); cmd_addr = 15'($urandom); cmd_wdata = 8'($urandom);
        cyc = 1;
        while (!rsp_valid && cyc < 5000) begin @(negedge clk); cyc++; end
        checks++;
        if (!rsp_valid) begin
            errors++; $display("FAIL %s_rsp: got no rsp_valid want rsp_valid", tag);
            return;
        end
        checks++;
        if (rsp_timeout !== exp_tmo) begin errors++; $display("FAIL %s_tmo: got %b want %b", tag, rsp_timeout, exp_tmo); end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b want 1", tag, cmd_ready); end
        checks++;
        if (n_strobe != exp_stb || (exp_stb == 2 && (n_lo != 1 || n_hi != 1)) || (exp_stb == 1 && n_inc != 1)) begin
            errors++;
            $display("FAIL %s_strobes: got %0d (lo%0d hi%0d inc%0d) want %0d", tag, n_strobe, n_lo, n_hi, n_inc, exp_stb);
        end
        if (exp_tmo) begin
            checks++;
            if (rsp_rdata !== last_rdata) begin errors++; $display("FAIL %s_rdata_keep: got %h want %h", tag, rsp_rdata, last_rdata); end
            checks++;
            if (cyc < TMO || cyc > TMO + 40) begin errors++; $display("FAIL %s_tmo_time: got %0d want %0d..%0d", tag, cyc, TMO, TMO + 40); end
            m_valid = 0;
        end else begin
            checks++;
            if (xfer_addr !== addr) begin errors++; $display("FAIL %s_xaddr: got %h want %h", tag, xfer_addr, addr); end
            if (wr) begin
                ref_mem[addr] = wd;
                checks++;
                if (cpld_mem[addr] !== wd) begin errors++; $display("FAIL %s_wdata: got %h want %h", tag, cpld_mem[addr], wd); end
            end else begin
                exp_rd = ref_mem[addr];
                checks++;
                if (rsp_rdata !== exp_rd) begin errors++; $display("FAIL %s_rdata: got %h want %h", tag, rsp_rdata, exp_rd); end
                last_rdata = exp_rd;
            end
            m_valid = 1; m_shadow = addr;
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0;
        #1 check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_idle_outputs("post_reset");
    endtask

    task automatic test_basic;
        run_cmd("wr1234", 1, 15'h1234, 8'hA5, 0);
        checks++;
        if (lo_data !== 8'h34 || hi_data !== 8'h12) begin
            errors++; $display("FAIL addr_bytes: got %h/%h want 34/12", lo_data, hi_data);
        end
        ref_mem[15'h1234] = 8'h5A; cpld_mem[15'h1234] = 8'h5A;
        run_cmd("rd1234", 0, 15'h1234, 8'h00, 0);
        run_cmd("rd1235", 0, 15'h1235, 8'h00, 0);
        checks++;
        if (n_inc != 1 || inc_bad != 0) begin errors++; $display("FAIL inc_strobe: got inc%0d oe_bad%0d want 1/0", n_inc, inc_bad); end
    endtask

    task automatic test_wrap_and_far;
        run_cmd("wr7fff", 1, 15'h7FFF, 8'h3C, 0);
        run_cmd("rd0000", 0, 15'h0000, 8'h00, 0);
        checks++;
        if (n_inc != 1) begin errors++; $display("FAIL wrap_inc: got %0d want 1", n_inc); end
        run_cmd("wr0010", 1, 15'h0010, 8'h77, 0);
        run_cmd("rd0012", 0, 15'h0012, 8'h00, 0);
    endtask

    task automatic test_timeout;
        no_ack_write = 1;
        run_cmd("wr_noack", 1, 15'h0012, 8'hEE, 1);
        no_ack_write = 0;
        run_cmd("rd_after_tmo", 0, 15'h0012, 8'h00, 0);
    endtask

    task automatic test_slow_ack;
        ack_delay = 200;
        run_cmd("rd_slow", 0, 15'h2222, 8'h00, 0);
        run_cmd("wr_slow", 1, 15'h2223, 8'h99, 0);
        ack_delay = 0;
    endtask

    task automatic test_random;
        logic [14:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0:       a = m_valid ? m_shadow : 15'($urandom);
                1:       a = m_shadow + 15'd1;
                default: a = 15'($urandom);
            endcase
            ack_delay = $urandom_range(0, 5);
            run_cmd("rand", 1'($urandom), a, 8'($urandom), 0);
        end
        ack_delay = 0;
    endtask

    task automatic test_reset_mid;
        int cyc;
        m_valid = 1; m_shadow = 15'h0500;
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1; cmd_write = 1; cmd_addr = 15'h4321; cmd_wdata = 8'h11;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        cyc = 0;
        while (!(strobe_addr && set_addr_hi) && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if (!(strobe_addr && set_addr_hi)) begin errors++; $display("FAIL mid_hi_seen: got 0 want 1"); end
        rst_n = 0;
        #1 check_idle_outputs("reset_mid");
        repeat (2) @(negedge clk);
        rst_n = 1;
        m_valid = 0; last_rdata = 0;
        @(negedge clk);
        run_cmd("after_rst", 0, 15'h4321, 8'h00, 0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ref_mem[i]  = 8'(i * 7 + 3);
            cpld_mem[i] = 8'(i * 7 + 3);
        end
        test_reset;
        test_basic;
        test_wrap_and_far;
        test_timeout;
        test_slow_ack;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench time limit");
    end
endmodule
